sequence_player: RTL and testbench

//  Plays back the stored Simon Says colour sequence to the player.

---
 rtl/simon_pkg.sv | 23 ++
 rtl/sequence_player_if.sv | 32 +++
 rtl/play_timer.sv | 33 +++
 rtl/sequence_player.sv | 141 ++++++++++++++
 tb/tb_sequence_player.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says playback path.
//   colour_t      : 2-bit colour code (0..3), one per LED
//   MAX_SEGMENTS  : depth of the segment array feeding the player
//   play_state_t  : playback FSM states
//   colour_onehot : colour code -> one-hot LED drive
package simon_pkg;

  localparam int MAX_SEGMENTS = 33;

  typedef logic [1:0] colour_t;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP,
    DONE
  } play_state_t;

  function automatic logic [3:0] colour_onehot(input colour_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/sequence_player_if.sv
// Bundle of the sequence player's data/handshake signals.
//   segment  : colour array from segments_array, entry 0 played first
//   seq_len  : number of entries to play (sampled on accepted start)
//   start    : single-cycle playback request
//   abort    : synchronous cancel of playback in progress
//   led      : one-hot colour drive, 4'b0000 = dark
//   play_idx : index of the entry being shown or gapped
//   busy     : high while a colour is lit or in its gap
//   done     : one-cycle pulse on normal completion
// master = game side (drives requests), slave = sequence_player.
interface sequence_player_if;

  logic [simon_pkg::MAX_SEGMENTS-1:0][1:0] segment;
  logic [5:0]                              seq_len;
  logic                                    start;
  logic                                    abort;
  logic [3:0]                              led;
  logic [5:0]                              play_idx;
  logic                                    busy;
  logic                                    done;

  modport master (
    output segment, seq_len, start, abort,
    input  led, play_idx, busy, done
  );

  modport slave (
    input  segment, seq_len, start, abort,
    output led, play_idx, busy, done
  );

endinterface

// File: rtl/play_timer.sv
// Loadable down-counter used for the lit and dark phases.
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high; clears the count
//   load     : load load_val this cycle (wins over counting)
//   load_val : value to load
//   zero     : high while the count is zero
// The count stops at zero instead of wrapping; the caller reloads it on
// every phase change.
module play_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays the stored Simon Says colour sequence on the four LEDs: each entry
// is lit for ON_CYCLES, then dark for GAP_CYCLES. busy covers the lit and
// dark phases; done pulses for one cycle after the last gap.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : sequence_player_if.slave (segment/seq_len/start/abort in,
//           led/play_idx/busy/done out, all outputs registered)
module sequence_player
  import simon_pkg::*;
#(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int GAP_CYCLES = 12_500_000,
  parameter int MAX_SEG    = MAX_SEGMENTS
) (
  input  logic              clk,
  input  logic              reset,
  sequence_player_if.slave  bus
);

  localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  // Keep at least one bit so ON_CYCLES = GAP_CYCLES = 1 still elaborates.
  localparam int T_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [T_W-1:0] ON_LD  = T_W'(ON_CYCLES - 1);
  localparam logic [T_W-1:0] GAP_LD = T_W'(GAP_CYCLES - 1);

  play_state_t r_state, w_state_nxt;
  logic [5:0]  r_len, w_len_nxt;
  logic [5:0]  r_idx, w_idx_nxt;
  colour_t     r_colour, w_colour_nxt;
  logic [3:0]  r_led, w_led_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        w_tmr_load;
  logic [T_W-1:0] w_tmr_val;
  logic        w_tmr_zero;
  logic [5:0]  w_len_clamped;

  assign w_len_clamped = (bus.seq_len > 6'(MAX_SEG)) ? 6'(MAX_SEG) : bus.seq_len;

  play_timer #(.WIDTH(T_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .zero     (w_tmr_zero)
  );

  // State, index, colour latch and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_idx    <= '0;
      r_colour <= '0;
      r_led    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_len    <= w_len_nxt;
      r_idx    <= w_idx_nxt;
      r_colour <= w_colour_nxt;
      r_led    <= w_led_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state logic. The colour is captured only when entering ON so the
  // lit LED ignores later segment changes. abort beats timer expiry.
  always_comb begin
    w_state_nxt  = r_state;
    w_len_nxt    = r_len;
    w_idx_nxt    = r_idx;
    w_colour_nxt = r_colour;
    w_tmr_load   = 1'b0;
    w_tmr_val    = ON_LD;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_len_nxt = w_len_clamped;
          w_idx_nxt = '0;
          if (w_len_clamped == '0) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt  = ON;
            w_colour_nxt = bus.segment[0];
            w_tmr_load   = 1'b1;
            w_tmr_val    = ON_LD;
          end
        end
      end
      ON: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end else if (w_tmr_zero) begin
          w_state_nxt = GAP;
          w_tmr_load  = 1'b1;
          w_tmr_val   = GAP_LD;
        end
      end
      GAP: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end else if (w_tmr_zero) begin
          if (r_idx == r_len - 6'd1) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt  = ON;
            w_idx_nxt    = r_idx + 6'd1;
            w_colour_nxt = bus.segment[r_idx + 6'd1];
            w_tmr_load   = 1'b1;
            w_tmr_val    = ON_LD;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    w_led_nxt  = (w_state_nxt == ON) ? colour_onehot(w_colour_nxt) : 4'b0000;
    w_busy_nxt = (w_state_nxt == ON) || (w_state_nxt == GAP);
    w_done_nxt = (w_state_nxt == DONE);
  end

  assign bus.led      = r_led;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.play_idx = r_idx;

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with short timing (4 lit, 2 dark).
// Expected per-cycle outputs are queued when a start is driven and popped
// one per clock as the DUT runs.
module tb_sequence_player;
  import simon_pkg::*;

  localparam int ON  = 4;
  localparam int GAP = 2;

  typedef struct packed {
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic [5:0] idx;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sequence_player_if bus();

  sequence_player #(
    .ON_CYCLES  (ON),
    .GAP_CYCLES (GAP),
    .MAX_SEG    (MAX_SEGMENTS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic obs_t mk(input logic [3:0] l, input logic b, input logic d,
                              input logic [5:0] i);
    obs_t o;
    o.led  = l;
    o.busy = b;
    o.done = d;
    o.idx  = i;
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t exp);
    obs_t got;
    got = mk(bus.led, bus.busy, bus.done, bus.play_idx);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed led=%b busy=%b done=%b idx=%0d, expected led=%b busy=%b done=%b idx=%0d",
             tag, got.led, got.busy, got.done, got.idx, exp.led, exp.busy, exp.done, exp.idx);
    end
  endtask

  // Queue the expected outputs for cycles 1.. after a start in cycle 0,
  // using the colours present on the segment array at start time.
  task automatic push_play(input int len_raw);
    int len;
    logic [5:0] ei;
    logic [3:0] oh;
    len = (len_raw > MAX_SEGMENTS) ? MAX_SEGMENTS : len_raw;
    for (int e = 0; e < len; e++) begin
      ei = 6'(e);
      oh = 4'b0001 << bus.segment[ei];
      for (int k = 0; k < ON; k++)  exp_q.push_back(mk(oh, 1'b1, 1'b0, ei));
      for (int k = 0; k < GAP; k++) exp_q.push_back(mk(4'b0000, 1'b1, 1'b0, ei));
    end
    ei = (len == 0) ? 6'd0 : 6'(len - 1);
    exp_q.push_back(mk(4'b0000, 1'b0, 1'b1, ei));
    exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, ei));
    exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, ei));
  endtask

  // Clock the DUT until the queue drains; start was raised in cycle 0.
  task automatic run(input string tag, input int repulse_at, input int abort_at,
                     input int segflip_at);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < 400) begin
      @(posedge clk);
      #1;
      c++;
      bus.start = (c == repulse_at);
      bus.abort = (c == abort_at);
      if (c == segflip_at) bus.segment[0] = ~bus.segment[0];
      chk($sformatf("%s_c%0d", tag, c), exp_q.pop_front());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.segment = '0;
    bus.seq_len = '0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;

    // Reset applied before any clock edge.
    #1;
    chk("reset_async", mk(4'b0000, 1'b0, 1'b0, 6'd0));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("idle_after_reset", mk(4'b0000, 1'b0, 1'b0, 6'd0));

    // Single entry, colour 2.
    bus.segment[0] = 2'b10;
    bus.seq_len    = 6'd1;
    bus.start      = 1'b1;
    push_play(1);
    run("len1", -1, -1, -1);

    // Three entries 0,3,1.
    bus.segment[0] = 2'd0;
    bus.segment[1] = 2'd3;
    bus.segment[2] = 2'd1;
    bus.seq_len    = 6'd3;
    bus.start      = 1'b1;
    push_play(3);
    run("len3", -1, -1, -1);

    // Zero length: immediate done, never busy.
    bus.seq_len = 6'd0;
    bus.start   = 1'b1;
    push_play(0);
    run("len0", -1, -1, -1);

    // Over-length request clamps to the full array.
    for (int i = 0; i < MAX_SEGMENTS; i++) begin
      bus.segment[i] = 2'($urandom_range(0, 3));
    end
    bus.seq_len = 6'd40;
    bus.start   = 1'b1;
    push_play(40);
    run("len40", -1, -1, -1);

    // start re-pulsed mid-play is ignored.
    bus.segment[0] = 2'd1;
    bus.seq_len    = 6'd1;
    bus.start      = 1'b1;
    push_play(1);
    run("restart", 3, -1, -1);

    // abort in cycle 2 returns to idle in cycle 3 without done.
    bus.segment[0] = 2'd3;
    bus.segment[1] = 2'd2;
    bus.segment[2] = 2'd1;
    bus.seq_len    = 6'd3;
    bus.start      = 1'b1;
    exp_q.push_back(mk(4'b1000, 1'b1, 1'b0, 6'd0));
    exp_q.push_back(mk(4'b1000, 1'b1, 1'b0, 6'd0));
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 6'd0));
    run("abort", -1, 2, -1);

    // Segment change while lit does not disturb the LED.
    bus.segment[0] = 2'd3;
    bus.seq_len    = 6'd1;
    bus.start      = 1'b1;
    push_play(1);
    run("segchg", -1, -1, 2);

    // Async reset in the middle of the first gap, then a fresh play.
    bus.segment[0] = 2'd2;
    bus.segment[1] = 2'd1;
    bus.seq_len    = 6'd2;
    bus.start      = 1'b1;
    push_play(2);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk($sformatf("pre_reset_c%0d", c), exp_q.pop_front());
    end
    #2;
    reset = 1'b1;
    #1;
    chk("reset_mid_gap", mk(4'b0000, 1'b0, 1'b0, 6'd0));
    #1;
    reset = 1'b0;
    exp_q.delete();
    bus.start = 1'b1;
    push_play(2);
    run("after_reset", -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
